// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between if_stage (master) and the instruction memory (slave).
// One outstanding request: imem_req/imem_addr are held until a single-cycle imem_valid pulse.
interface if_stage_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage plus IF/ID pipeline register.
// Owns the PC, fetches from a variable-latency memory (one request in flight),
// honours PCWrite/IF_ID_Write stalls and PCSrc redirects.
// Optional feature: define IF_PERF_CNT_EN to add saturating perf_fetched/perf_stall counters.
module if_stage #(
    parameter logic [63:0] PC_RESET = 64'h0,
    parameter logic [31:0] NOP_INST = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        IF_ID_Write,
    input  logic        PCSrc,
    input  logic [63:0] BranchTarget,
    if_stage_if.master  imem,
    output logic [31:0] instruction,
    output logic [63:0] PCPlus4Out,
    output logic [63:0] PC_IFID,
    output logic        if_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] drop_addr_q, drop_addr_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] inst_q, inst_d;
    logic [63:0] pc4_q, pc4_d;
    logic [63:0] pcid_q, pcid_d;
    logic        valid_q, valid_d;

    logic        advance;
    logic        deliver;
    logic [31:0] deliver_word;
    logic [63:0] pc_plus4;

    // Next-state, fetch bus and IF/ID load logic; redirect overrides everything at the end.
    always_comb begin
        advance        = PCWrite & IF_ID_Write;
        pc_plus4       = pc_q + 64'd4;
        state_d        = state_q;
        pc_d           = pc_q;
        drop_addr_d    = drop_addr_q;
        skid_d         = skid_q;
        inst_d         = inst_q;
        pc4_d          = pc4_q;
        pcid_d         = pcid_q;
        valid_d        = valid_q;
        deliver        = 1'b0;
        deliver_word   = skid_q;
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                imem.imem_req = 1'b1;
                if (imem.imem_valid) begin
                    if (advance) begin
                        deliver      = 1'b1;
                        deliver_word = imem.imem_rdata;
                    end else begin
                        skid_d  = imem.imem_rdata;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (advance) begin
                    deliver      = 1'b1;
                    deliver_word = skid_q;
                    state_d      = S_WAIT;
                end
            end
            S_DROP: begin
                imem.imem_req  = 1'b1;
                imem.imem_addr = drop_addr_q;
                if (imem.imem_valid) begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (deliver) begin
            pc_d    = pc_plus4;
            inst_d  = deliver_word;
            pc4_d   = pc_plus4;
            pcid_d  = pc_q;
            valid_d = 1'b1;
        end else if (IF_ID_Write) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end

        // Redirect: the PC moves at once, but an in-flight request keeps its old
        // address on the bus (drop_addr) until its response arrives and is thrown away.
        if (PCSrc) begin
            pc_d    = BranchTarget;
            inst_d  = NOP_INST;
            valid_d = 1'b0;
            pc4_d   = pc4_q;
            pcid_d  = pcid_q;
            skid_d  = '0;
            case (state_q)
                S_WAIT: begin
                    drop_addr_d = pc_q;
                    state_d     = imem.imem_valid ? S_WAIT : S_DROP;
                end
                S_DROP: begin
                    state_d = imem.imem_valid ? S_WAIT : S_DROP;
                end
                default: begin
                    state_d = S_WAIT;
                end
            endcase
        end
    end

    // State, PC, skid buffer and IF/ID register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pc_q        <= PC_RESET;
            drop_addr_q <= '0;
            skid_q      <= '0;
            inst_q      <= NOP_INST;
            pc4_q       <= '0;
            pcid_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            skid_q      <= skid_d;
            inst_q      <= inst_d;
            pc4_q       <= pc4_d;
            pcid_q      <= pcid_d;
            valid_q     <= valid_d;
        end
    end

    assign instruction = inst_q;
    assign PCPlus4Out  = pc4_q;
    assign PC_IFID     = pcid_q;
    assign if_valid    = valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic        stall_cycle;

    // Saturating counters: delivered instructions and fetch-stall cycles.
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        stall_cycle    = (state_q == S_HOLD) || ((state_q == S_WAIT) && !imem.imem_valid);
        if (deliver && !PCSrc && (perf_fetched_q != '1)) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (stall_cycle && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios with literal expectations,
// then randomized stalls, redirects and memory latency against a behavioural model.
`timescale 1ns/1ps
module tb_if_stage;
    localparam logic [63:0] PC_RST = 64'h100;
    localparam logic [31:0] NOP    = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCWrite, IF_ID_Write, PCSrc;
    logic [63:0] BranchTarget;
    logic [31:0] instruction;
    logic [63:0] PCPlus4Out, PC_IFID;
    logic        if_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall;
`endif

    if_stage_if bus();

    if_stage #(.PC_RESET(PC_RST), .NOP_INST(NOP)) dut (
        .clk          (clk),
        .reset        (reset),
        .PCWrite      (PCWrite),
        .IF_ID_Write  (IF_ID_Write),
        .PCSrc        (PCSrc),
        .BranchTarget (BranchTarget),
        .imem         (bus),
        .instruction  (instruction),
        .PCPlus4Out   (PCPlus4Out),
        .PC_IFID      (PC_IFID),
        .if_valid     (if_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
    endfunction

    // ---------------- memory responder ----------------
    logic        mem_busy = 1'b0;
    int unsigned mem_cnt  = 0;
    logic [63:0] mem_addr = '0;
    int unsigned mem_lat  = 1;   // 0 = random 1..3
    int unsigned mem_nreq = 0;
    int unsigned inject_cnt  = 0;
    int unsigned inject_done = 0;

    initial begin
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
    end

    always @(negedge clk) begin
        bus.imem_valid = 1'b0;
        if (mem_busy && bus.imem_req && reset)
            check("addr_stable", bus.imem_addr, mem_addr);
        if (!reset) begin
            mem_busy = 1'b0;
        end else if (inject_cnt != inject_done) begin
            inject_done    = inject_cnt;
            bus.imem_valid = 1'b1;
            bus.imem_rdata = 32'hDEAD_BEEF;
        end else if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                bus.imem_valid = 1'b1;
                bus.imem_rdata = word_of(mem_addr);
                mem_busy       = 1'b0;
            end
        end else if (bus.imem_req) begin
            mem_busy = 1'b1;
            mem_addr = bus.imem_addr;
            mem_cnt  = (mem_lat == 0) ? $urandom_range(1, 3) : mem_lat;
            mem_nreq++;
        end
    end

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        started;   // the post-reset idle cycle has passed
        logic        discard;   // outstanding response must be thrown away
        logic        buf_full;  // a fetched word waits for the stall to clear
        logic        ifv;
        logic [63:0] pc;
        logic [63:0] old;       // address of the request being discarded
        logic [63:0] pc4;
        logic [63:0] pcid;
        logic [31:0] bufw;
        logic [31:0] inst;
        logic [31:0] fetched;
        logic [31:0] stall;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r         = '0;
        r.pc      = PC_RST;
        r.inst    = NOP;
        return r;
    endfunction

    function automatic model_t step(input model_t s, input logic pcw, input logic ifw,
                                    input logic src, input logic [63:0] tgt,
                                    input logic vld, input logic [31:0] rd);
        model_t      n;
        logic        req_now;
        logic        got;
        logic [31:0] w;
        n       = s;
        req_now = s.started && !s.buf_full;
        got     = 1'b0;
        w       = '0;
        if ((s.buf_full || (req_now && !s.discard && !vld)) && (s.stall != 32'hFFFF_FFFF))
            n.stall = s.stall + 32'd1;
        if (src) begin
            n.pc       = tgt;
            n.inst     = NOP;
            n.ifv      = 1'b0;
            n.buf_full = 1'b0;
            n.started  = 1'b1;
            n.discard  = req_now && !vld;
            if (n.discard && !s.discard) n.old = s.pc;
        end else begin
            if (!s.started) n.started = 1'b1;
            else if (s.discard) begin
                if (vld) n.discard = 1'b0;
            end else if (s.buf_full) begin
                if (pcw && ifw) begin got = 1'b1; w = s.bufw; n.buf_full = 1'b0; end
            end else if (vld) begin
                if (pcw && ifw) begin got = 1'b1; w = rd; end
                else begin n.buf_full = 1'b1; n.bufw = rd; end
            end
            if (got) begin
                n.inst = w;
                n.pc4  = s.pc + 64'd4;
                n.pcid = s.pc;
                n.ifv  = 1'b1;
                n.pc   = s.pc + 64'd4;
                if (s.fetched != 32'hFFFF_FFFF) n.fetched = s.fetched + 32'd1;
            end else if (ifw) begin
                n.inst = NOP;
                n.ifv  = 1'b0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= model_reset();
        else m <= step(m, PCWrite, IF_ID_Write, PCSrc, BranchTarget, bus.imem_valid, bus.imem_rdata);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("req", bus.imem_req, m.started && !m.buf_full);
        if (m.started && !m.buf_full)
            check("addr", bus.imem_addr, m.discard ? m.old : m.pc);
        check("instruction", instruction, m.inst);
        check("if_valid", if_valid, m.ifv);
        check("PCPlus4Out", PCPlus4Out, m.pc4);
        check("PC_IFID", PC_IFID, m.pcid);
`ifdef IF_PERF_CNT_EN
        check("perf_fetched", perf_fetched, m.fetched);
        check("perf_stall", perf_stall, m.stall);
`endif
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; PCWrite = 1'b1; IF_ID_Write = 1'b1; PCSrc = 1'b0; BranchTarget = '0;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        tick();
        check("rst_req", bus.imem_req, 0);
        check("rst_inst", instruction, 0);
        check("rst_valid", if_valid, 0);
        check("rst_pc4", PCPlus4Out, 0);
        check("rst_pcid", PC_IFID, 0);

        // 1: reset release, fetch starts at PC_RESET one cycle later
        @(posedge clk); #1 reset = 1'b1;
        tick();
        check("t1_idle_req", bus.imem_req, 0);
        tick();
        check("t1_req", bus.imem_req, 1);
        check("t1_addr", bus.imem_addr, 64'h100);

        // 2: 1-cycle memory, no stalls
        tick(); tick();
        check("t2_a_inst", instruction, 32'hC0DE_0100);
        check("t2_a_pc4", PCPlus4Out, 64'h104);
        check("t2_a_pc", PC_IFID, 64'h100);
        check("t2_a_v", if_valid, 1);
        tick(); tick();
        check("t2_b_inst", instruction, 32'hC0DE_0104);
        check("t2_b_pc4", PCPlus4Out, 64'h108);
        tick(); tick();
        check("t2_c_inst", instruction, 32'hC0DE_0108);
        check("t2_c_pc", PC_IFID, 64'h108);
        check("t2_addr", bus.imem_addr, 64'h10C);

        // 3: response arrives under a 3-cycle stall
        PCWrite = 1'b0; IF_ID_Write = 1'b0;
        tick();
        check("t3_hold1", instruction, 32'hC0DE_0108);
        tick();
        check("t3_req_off", bus.imem_req, 0);
        check("t3_hold2", instruction, 32'hC0DE_0108);
        tick();
        check("t3_req_off2", bus.imem_req, 0);
        PCWrite = 1'b1; IF_ID_Write = 1'b1; mem_lat = 3;
        tick();
        check("t3_d_inst", instruction, 32'hC0DE_010C);
        check("t3_d_pc4", PCPlus4Out, 64'h110);
        check("t3_addr", bus.imem_addr, 64'h110);
        check("t3_no_refetch", mem_nreq, 5);

        // 4: redirect one cycle after the request, 3-cycle memory
        tick();
        PCSrc = 1'b1; BranchTarget = 64'h400;
        tick();
        PCSrc = 1'b0;
        check("t4_old_addr", bus.imem_addr, 64'h110);
        check("t4_flush_v", if_valid, 0);
        check("t4_flush_i", instruction, 0);
        tick();
        mem_lat = 1;
        tick();
        check("t4_new_addr", bus.imem_addr, 64'h400);
        check("t4_bubble", if_valid, 0);

        // 5: redirect while IF/ID is stalled
        tick(); tick();
        check("t5_inst", instruction, 32'hC0DE_0400);
        PCSrc = 1'b1; BranchTarget = 64'h800; IF_ID_Write = 1'b0;
        tick();
        check("t5_flush_v", if_valid, 0);
        check("t5_flush_i", instruction, 0);
        PCSrc = 1'b0; IF_ID_Write = 1'b1; mem_lat = 3;
        tick();
        check("t5_addr", bus.imem_addr, 64'h800);

        // 6: reset mid-WAIT, stray response pulse right after release
        reset = 1'b0; mem_lat = 1;
        tick();
        check("t6_rst_req", bus.imem_req, 0);
        tick();
        @(posedge clk); #1 reset = 1'b1; inject_cnt++;
        tick();
        check("t6_idle_req", bus.imem_req, 0);
        check("t6_idle_v", if_valid, 0);
`ifdef IF_PERF_CNT_EN
        check("t6_pf", perf_fetched, 0);
        check("t6_ps", perf_stall, 0);
`endif
        tick();
        check("t6_addr", bus.imem_addr, 64'h100);
        check("t6_v", if_valid, 0);
        tick(); tick();
        check("t6_inst", instruction, 32'hC0DE_0100);

        // 7: PC+4 wraps at the top of the address space
        PCSrc = 1'b1; BranchTarget = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        PCSrc = 1'b0;
        tick();
        check("t7_addr", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick(); tick();
        check("t7_inst", instruction, 32'hC0DE_0003);
        check("t7_pc4", PCPlus4Out, 64'h0);
        check("t7_pcid", PC_IFID, 64'hFFFF_FFFF_FFFF_FFFC);
        check("t7_next", bus.imem_addr, 64'h0);

        // random phase
        mem_lat = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            PCWrite     = ($urandom_range(0, 9) < 8);
            IF_ID_Write = ($urandom_range(0, 9) < 8);
            PCSrc       = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                BranchTarget = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3) * 4);
            else
                BranchTarget = {32'h0, $urandom} & ~64'h3;
            if (i == 1500) reset = 1'b0;
            if (i == 1502) reset = 1'b1;
        end
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
